row_sequencer: RTL and testbench

Per-line scheduler that feeds the row renderer.
- Accepts one trace result (side, size, texu) per display line from the wall tracer over a valid/ready handshake.
- Double-buffers the result and swaps it in at each line start.
- During horizontal blanking, computes the texture-v step and start offset with a sequential divider and a sequential multiplier.
- During the visible line, generates texv incrementally so the renderer needs no per-pixel divide.

---
 rtl/row_sequencer_if.sv | 12 +
 rtl/row_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_row_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_sequencer_if.sv
// Trace-result handshake from the wall tracer into the row sequencer.
// The tracer is the master; the sequencer is the slave.
interface row_sequencer_if;
    logic        valid;
    logic        ready;
    logic        side;
    logic [10:0] size;
    logic [5:0]  texu;

    modport master (output valid, side, size, texu, input ready);
    modport slave  (input valid, side, size, texu, output ready);
endinterface

// File: rtl/row_sequencer.sv
// Per-line scheduler for the row renderer: double-buffers one trace result per line,
// derives the texture-v step/offset in hblank, and walks texv across the visible span.
module row_sequencer #(
    parameter int H_VIEW = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic        visible,
    input  logic [9:0]  hpos,
    row_sequencer_if.slave trace,
    output logic        side,
    output logic [10:0] size,
    output logic [5:0]  texu,
    output logic [5:0]  texv,
    output logic        row_valid,
    output logic        busy,
    output logic        underrun,
    output logic [7:0]  underrun_count
);
    localparam int HALF = H_VIEW / 2;
    localparam logic signed [11:0] HALF_S = 12'(HALF);

    typedef enum logic [2:0] {IDLE, DIV, MUL, ARM, RUN} state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction

    state_t      state;
    logic        ready_r;
    logic        pend_full;
    logic        pend_side;
    logic [10:0] pend_size;
    logic [5:0]  pend_texu;
    logic [3:0]  cnt;
    logic [10:0] rem;
    logic [15:0] quo;
    logic [15:0] step;
    logic [15:0] mcand;
    logic [10:0] mplier;
    logic [15:0] acc0;
    logic [15:0] acc;

    logic        handshake;
    logic        pend_full_nxt;
    logic        in_span;
    logic [11:0] div_shift;
    logic        div_ge;
    logic [10:0] div_rem_nxt;
    logic [15:0] div_quo_nxt;
    logic [10:0] mul_op;
    logic [15:0] mul_add;

    assign trace.ready = ready_r;
    assign handshake   = trace.valid && ready_r;
    assign pend_full_nxt = line_start ? 1'b0 : (handshake ? 1'b1 : pend_full);

    // Same hit test as the renderer; HALF+size may wrap only when size > HALF already holds.
    always_comb begin
        logic signed [11:0] size_s;
        logic signed [11:0] hpos_s;
        size_s  = signed'({1'b0, size});
        hpos_s  = signed'({2'b0, hpos});
        in_span = (size_s > HALF_S) ||
                  ((HALF_S - size_s <= hpos_s) && (hpos_s <= HALF_S + size_s));
    end

    // Restoring division of 32768 by size: quo starts as the dividend and fills with quotient bits.
    always_comb begin
        div_shift   = {rem, quo[15]};
        div_ge      = div_shift >= {1'b0, size};
        div_rem_nxt = div_ge ? 11'(div_shift - {1'b0, size}) : div_shift[10:0];
        div_quo_nxt = {quo[14:0], div_ge};
        mul_op      = (size > 11'(HALF)) ? size - 11'(HALF) : 11'd0;
        mul_add     = mplier[0] ? mcand : 16'd0;
    end

    always_comb begin
        texv = 6'd0;
        if (row_valid && in_span && (state == RUN || (state == ARM && visible)))
            texv = acc[15:10];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            ready_r        <= 1'b0;
            pend_full      <= 1'b0;
            pend_side      <= 1'b0;
            pend_size      <= '0;
            pend_texu      <= '0;
            side           <= 1'b0;
            size           <= '0;
            texu           <= '0;
            row_valid      <= 1'b0;
            busy           <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            step           <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc0           <= '0;
            acc            <= '0;
        end else begin
            underrun  <= 1'b0;
            pend_full <= pend_full_nxt;
            ready_r   <= !pend_full_nxt;
            if (handshake && !line_start) begin
                pend_side <= trace.side;
                pend_size <= trace.size;
                pend_texu <= trace.texu;
            end

            if (line_start) begin
                if (pend_full || handshake) begin
                    side      <= pend_full ? pend_side : trace.side;
                    size      <= pend_full ? pend_size : trace.size;
                    texu      <= pend_full ? pend_texu : trace.texu;
                    row_valid <= 1'b1;
                    state     <= DIV;
                    busy      <= 1'b1;
                    cnt       <= '0;
                    rem       <= '0;
                    quo       <= 16'h8000;
                end else begin
                    row_valid      <= 1'b0;
                    underrun       <= 1'b1;
                    underrun_count <= sat_inc8(underrun_count);
                    state          <= ARM;
                    busy           <= 1'b0;
                    acc            <= '0;
                    step           <= '0;
                end
            end else begin
                case (state)
                    DIV: begin
                        if (size == 11'd0 || cnt == 4'd15) begin
                            step   <= (size == 11'd0) ? 16'd0 : div_quo_nxt;
                            mcand  <= (size == 11'd0) ? 16'd0 : div_quo_nxt;
                            mplier <= mul_op;
                            acc0   <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            rem <= div_rem_nxt;
                            quo <= div_quo_nxt;
                            cnt <= cnt + 4'd1;
                        end
                    end
                    MUL: begin
                        // Product is known to fit 16 bits, so wrapped high partials never matter.
                        acc0   <= acc0 + mul_add;
                        mcand  <= {mcand[14:0], 1'b0};
                        mplier <= {1'b0, mplier[10:1]};
                        cnt    <= cnt + 4'd1;
                        if (cnt == 4'd10) begin
                            acc   <= acc0 + mul_add;
                            busy  <= 1'b0;
                            state <= ARM;
                        end
                    end
                    ARM: begin
                        if (visible) begin
                            state <= RUN;
                            if (in_span)
                                acc <= sat_add16(acc, step);
                        end
                    end
                    RUN: begin
                        if (!visible)
                            state <= IDLE;
                        else if (in_span)
                            acc <= sat_add16(acc, step);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_row_sequencer.sv
// Scoreboard bench for row_sequencer: the driver pushes per-line and per-pixel expectations
// from an arithmetic reference model; independent monitors pop and compare.
module tb_row_sequencer;
    typedef struct packed {
        logic        side;
        logic [10:0] size;
        logic [5:0]  texu;
    } trace_t;

    typedef struct packed {
        logic   rv;
        trace_t t;
    } line_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic        visible = 1'b0;
    logic [9:0]  hpos = '0;
    logic        side;
    logic [10:0] size;
    logic [5:0]  texu;
    logic [5:0]  texv;
    logic        row_valid;
    logic        busy;
    logic        underrun;
    logic [7:0]  underrun_count;

    row_sequencer_if tif ();

    row_sequencer #(.H_VIEW(640)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .line_start     (line_start),
        .visible        (visible),
        .hpos           (hpos),
        .trace          (tif),
        .side           (side),
        .size           (size),
        .texu           (texu),
        .texv           (texv),
        .row_valid      (row_valid),
        .busy           (busy),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int     exp_pix[$];
    line_t  exp_line[$];
    int     exp_urun[$];

    trace_t mp[$];
    trace_t act = '0;
    int     ucount = 0;

    task automatic chk(input string name, input longint actual, input longint expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input trace_t t);
        tif.side = t.side;
        tif.size = t.size;
        tif.texu = t.texu;
    endtask

    function automatic trace_t mk(input int sz, input int sd, input int tu);
        trace_t t;
        t.side = 1'(sd);
        t.size = 11'(sz);
        t.texu = 6'(tu);
        return t;
    endfunction

    function automatic trace_t rand_trace();
        int sz;
        case ($urandom_range(0, 4))
            0:       sz = 0;
            1:       sz = 320;
            2:       sz = int'($urandom_range(1, 400));
            default: sz = int'($urandom_range(0, 2047));
        endcase
        return mk(sz, int'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
    endfunction

    // Reference: texv at pixel h is acc>>10 where acc = acc0 + step * (span pixels already passed).
    task automatic push_pixels(input bit rv, input int sz);
        int st;
        int a;
        bit sp;
        st = (sz == 0) ? 0 : 32768 / sz;
        a  = (sz > 320) ? (sz - 320) * st : 0;
        for (int h = 0; h < 640; h++) begin
            sp = (sz > 320) || ((320 - sz <= h) && (h <= 320 + sz));
            exp_pix.push_back((rv && sp) ? (a >> 10) : 0);
            if (sp) a = (a + st > 65535) ? 65535 : a + st;
        end
    endtask

    task automatic run_line(input bit pre, input bit byp, input bit hold, input bit vis,
                            input trace_t tp, input trace_t tbp, input trace_t th);
        bit    rv;
        int    nb;
        line_t le;
        if (pre) begin
            drive(tp);
            tif.valid = 1'b1;
            chk("ready_pre", tif.ready, 1);
            tick();
            tif.valid = 1'b0;
            mp.push_back(tp);
        end
        tick();
        tick();
        if (hold) begin
            drive(th);
            tif.valid = 1'b1;
            chk("ready_held", tif.ready, 0);
            tick();
        end
        line_start = 1'b1;
        if (byp) begin
            drive(tbp);
            tif.valid = 1'b1;
            chk("ready_bypass", tif.ready, 1);
        end
        if (mp.size() > 0) begin
            act = mp.pop_front();
            rv  = 1'b1;
        end else if (byp) begin
            act = tbp;
            rv  = 1'b1;
        end else begin
            rv = 1'b0;
            ucount = (ucount < 255) ? ucount + 1 : 255;
            exp_urun.push_back(ucount);
        end
        if (vis) begin
            le.rv = rv;
            le.t  = act;
            exp_line.push_back(le);
            push_pixels(rv, int'(act.size));
        end
        tick();
        line_start = 1'b0;
        if (byp) tif.valid = 1'b0;
        nb = 0;
        for (int i = 0; i < 39; i++) begin
            if (busy) nb++;
            if (hold && i == 0) chk("ready_after_ls", tif.ready, 1);
            tick();
            if (hold && i == 0) begin
                tif.valid = 1'b0;
                mp.push_back(th);
            end
        end
        if (!rv) chk("busy_cycles_underrun", nb, 0);
        else if (act.size != 11'd0) chk("busy_cycles", nb, 27);
        if (vis) begin
            for (int h = 0; h < 640; h++) begin
                visible = 1'b1;
                hpos    = 10'(h);
                tick();
            end
            visible = 1'b0;
            hpos    = '0;
        end
        repeat (3) tick();
    endtask

    // Pixel / line-parameter monitor.
    always @(negedge clk) begin
        if (reset_n && visible) begin
            if (exp_pix.size() == 0) begin
                chk("texv_unexpected_pixel", 1, 0);
            end else begin
                int e;
                e = exp_pix.pop_front();
                chk($sformatf("texv@%0d", hpos), texv, e);
            end
            if (hpos == 10'd0) begin
                if (exp_line.size() == 0) begin
                    chk("line_unexpected", 1, 0);
                end else begin
                    line_t le;
                    le = exp_line.pop_front();
                    chk("line_params", {row_valid, side, size, texu}, {le.rv, le.t});
                end
            end
        end
    end

    // Underrun monitor.
    always @(negedge clk) begin
        if (reset_n && underrun) begin
            if (exp_urun.size() == 0) begin
                chk("underrun_unexpected", 1, 0);
            end else begin
                int e;
                e = exp_urun.pop_front();
                chk("underrun_count", underrun_count, e);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {tif.ready, side, size, texu, texv, row_valid, busy, underrun, underrun_count}, 0);
    endtask

    initial begin
        trace_t z;
        bit pre;
        bit byp;
        bit hold;
        int sel;
        z = '0;
        tif.valid = 1'b0;
        drive(z);

        repeat (3) tick();
        chk_all_zero("reset_outputs");
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", tif.ready, 1);

        run_line(1, 0, 0, 1, mk(64, 1, 17), z, z);
        run_line(1, 0, 0, 1, mk(400, 0, 42), z, z);
        run_line(0, 0, 0, 1, z, z, z);
        run_line(1, 0, 1, 1, mk(10, 1, 3), z, mk(20, 0, 9));
        run_line(0, 0, 0, 1, z, z, z);
        run_line(0, 1, 0, 1, z, mk(0, 1, 55), z);
        for (int i = 0; i < 300; i++) run_line(0, 0, 0, 0, z, z, z);
        chk("underrun_saturated", underrun_count, 255);

        // Reset five cycles into DIV.
        drive(mk(100, 1, 7));
        tif.valid = 1'b1;
        chk("ready_pre_reset", tif.ready, 1);
        tick();
        tif.valid = 1'b0;
        tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (2) tick();
        chk("busy_mid_div", busy, 1);
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_all_zero("reset_mid_div_outputs");
        tick();
        chk("ready_after_mid_reset", tif.ready, 1);
        mp.delete();
        act = '0;
        ucount = 0;

        for (int n = 0; n < 20; n++) begin
            pre = 1'b0;
            byp = 1'b0;
            hold = 1'b0;
            if (mp.size() == 0) begin
                sel = int'($urandom_range(0, 3));
                pre  = (sel == 0 || sel == 3);
                byp  = (sel == 1);
                hold = (sel == 3);
            end else begin
                hold = 1'($urandom_range(0, 1));
            end
            run_line(pre, byp, hold, 1, rand_trace(), rand_trace(), rand_trace());
        end

        repeat (5) tick();
        chk("pixels_left", exp_pix.size(), 0);
        chk("lines_left", exp_line.size(), 0);
        chk("underruns_left", exp_urun.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
